// File: rtl/scan_chain_ctrl.sv
// Sequences one mux-scan chain: optional SETB preset, serial load, functional capture, serial unload + compare.
// Latency: START edge to DONE = [SET_CYCLES if preset] + 2*CHAIN_LEN + CAPTURE_CYCLES + 1 cycles.
// Backpressure: none; START is honoured only in IDLE, ignored (not queued) while BUSY.
//
// Ports:
//   CLK, RST        clock shared with the chain flops; synchronous active-high reset
//   START           single-cycle request, sampled only in IDLE together with PRESET_REQ, PAT_IN, EXP_IN
//   PAT_IN          pattern; bit i ends up in flop i (flop 0 nearest SI)
//   EXP_IN          expected response compared against RESP_OUT
//   SO              Q of the last chain flop
//   SE, SI          scan enable / scan in, decoded from registered state only
//   CHAIN_SETB      active-low set to every chain flop, low only in PRESET
//   BUSY, DONE      BUSY high outside IDLE; DONE one-cycle pulse when RESP_OUT/MISMATCH are valid
//   RESP_OUT        unloaded response; bit i = captured value of flop i
//   MISMATCH        RESP_OUT != EXP_IN, valid from DONE until the next START
//   SIGNATURE       16-bit MISR of the unloaded stream when SCAN_CTRL_MISR_EN is defined, else 0
//
// Build option: define SCAN_CTRL_MISR_EN to include the x^16+x^12+x^5+1 MISR.

module scan_chain_ctrl #(
    parameter int CHAIN_LEN      = 8,
    parameter int CAPTURE_CYCLES = 1,
    parameter int SET_CYCLES     = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 PRESET_REQ,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic [CHAIN_LEN-1:0] EXP_IN,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 CHAIN_SETB,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESP_OUT,
    output logic                 MISMATCH,
    output logic [15:0]          SIGNATURE
);

    localparam int MAX_A   = (CHAIN_LEN > SET_CYCLES) ? CHAIN_LEN : SET_CYCLES;
    localparam int MAX_CNT = (MAX_A > CAPTURE_CYCLES) ? MAX_A : CAPTURE_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESET  = 3'd1,
        LOAD    = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        DONE_ST = 3'd5
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_load;
    logic                 cnt_zero;
    logic [CHAIN_LEN-1:0] ps;
    logic [CHAIN_LEN-1:0] er;
    logic [CHAIN_LEN-1:0] ps_nxt;
    logic [CHAIN_LEN-1:0] resp_nxt;

    assign cnt_zero = (cnt == '0);

    // Pattern leaves MSB first; response enters at the LSB so the first
    // sample (flop CHAIN_LEN-1) finishes in the MSB. The truncating casts
    // keep both shifts legal for CHAIN_LEN == 1.
    assign ps_nxt   = CHAIN_LEN'({ps, 1'b0});
    assign resp_nxt = CHAIN_LEN'({RESP_OUT, SO});

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        SE         = 1'b0;
        SI         = 1'b0;
        CHAIN_SETB = 1'b1;
        BUSY       = 1'b1;
        DONE       = 1'b0;
        case (state)
            IDLE: begin
                BUSY = 1'b0;
                if (START) begin
                    state_nxt = PRESET_REQ ? PRESET : LOAD;
                end
            end
            PRESET: begin
                CHAIN_SETB = 1'b0;
                if (cnt_zero) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                SE = 1'b1;
                SI = ps[CHAIN_LEN-1];
                if (cnt_zero) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (cnt_zero) begin
                    state_nxt = UNLOAD;
                end
            end
            UNLOAD: begin
                SE = 1'b1;
                if (cnt_zero) begin
                    state_nxt = DONE_ST;
                end
            end
            DONE_ST: begin
                DONE      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Each timed state runs for (load value + 1) cycles: the counter is
    // reloaded on entry and the state exits on the cycle it reads zero.
    always_comb begin
        cnt_load = '0;
        case (state_nxt)
            PRESET:       cnt_load = CW'(SET_CYCLES - 1);
            LOAD, UNLOAD: cnt_load = CW'(CHAIN_LEN - 1);
            CAPTURE:      cnt_load = CW'(CAPTURE_CYCLES - 1);
            default:      cnt_load = '0;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt      <= '0;
            ps       <= '0;
            er       <= '0;
            RESP_OUT <= '0;
            MISMATCH <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                cnt <= cnt_load;
            end else if (!cnt_zero) begin
                cnt <= cnt - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (START) begin
                        ps       <= PAT_IN;
                        er       <= EXP_IN;
                        RESP_OUT <= '0;
                        MISMATCH <= 1'b0;
                    end
                end
                LOAD: begin
                    ps <= ps_nxt;
                end
                UNLOAD: begin
                    RESP_OUT <= resp_nxt;
                    // Compare on the final shift so MISMATCH is valid in the DONE cycle.
                    if (cnt_zero) begin
                        MISMATCH <= (resp_nxt != er);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SCAN_CTRL_MISR_EN
    logic [15:0] misr;
    logic [15:0] misr_nxt;

    // Galois form of x^16+x^12+x^5+1 with the scan-out sample folded into bit 0.
    assign misr_nxt = {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ {15'd0, SO};

    always_ff @(posedge CLK) begin
        if (RST) begin
            misr      <= '0;
            SIGNATURE <= '0;
        end else if (state == IDLE && START) begin
            misr <= 16'hFFFF;
        end else if (state == UNLOAD) begin
            misr <= misr_nxt;
            if (cnt_zero) begin
                SIGNATURE <= misr_nxt;
            end
        end
    end
`else
    assign SIGNATURE = 16'h0000;
`endif

endmodule
